// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank write-port arbiter.
// Default geometry and the arbiter state encoding.
package reg_bank_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 4;
  localparam int BANK_DEPTH  = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/reg_rr_pick.sv
// Combinational round-robin picker: first set request at or
// after ptr, searching upward with wrap.
module reg_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = PW'((int'(ptr) + i) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port
// between requesters issuing address-incrementing bursts.
module reg_bank_write_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      write_en,
  output logic [ADDR_W-1:0]         add_line,
  output logic [DATA_W-1:0]         data_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state_q, state_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                pick_found;
  logic [PW-1:0]       pick_idx;
  logic                own_req;
  logic [PW-1:0]       next_ptr;
  logic [NUM_REQ-1:0]  one;

  logic [ADDR_W-1:0]   addr_a [NUM_REQ];
  logic [ADDR_W-1:0]   len_a  [NUM_REQ];
  logic [DATA_W-1:0]   data_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign len_a[g]  = req_len[g*ADDR_W +: ADDR_W];
    assign data_a[g] = req_data[g*DATA_W +: DATA_W];
  end

  reg_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign one      = NUM_REQ'(1);
  assign own_req  = req[owner_q];
  assign next_ptr = (owner_q == PW'(NUM_REQ - 1))
                  ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    base_d   = base_q;
    len_d    = len_q;
    beat_d   = beat_q;
    gnt_d    = gnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          base_d  = addr_a[pick_idx];
          len_d   = len_a[pick_idx];
          beat_d  = '0;
          gnt_d   = one << pick_idx;
          state_d = BURST;
        end
      end
      BURST: begin
        if (own_req) begin
          data_d = data_a[owner_q];
          addr_d = base_q + beat_q;
          we_d   = 1'b1;
        end
        // last beat and abort both hand the turn to the next requester
        if (!own_req || beat_q == len_q) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      base_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign req_ack  = gnt_q & req;
  assign gnt      = gnt_q;
  assign busy     = (state_q == BURST);
  assign write_en = we_q;
  assign add_line = addr_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed-vector bench for reg_bank_write_arbiter.
// Inputs change on the falling edge, outputs are checked 1ns later.
module tb_reg_bank_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [15:0] req_len;
  logic [127:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  gnt;
  logic        busy;
  logic        write_en;
  logic [3:0]  add_line;
  logic [31:0] data_out;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  reg_bank_write_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .req_data (req_data),
    .req_ack  (req_ack),
    .gnt      (gnt),
    .busy     (busy),
    .write_en (write_en),
    .add_line (add_line),
    .data_out (data_out)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] d;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        busy;
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dout;
  } vec_t;

  vec_t tv [38];

  function automatic vec_t mk(
    input logic [3:0] r, input logic [31:0] d,
    input logic [15:0] l, input logic [3:0] g,
    input logic [3:0] a, input logic b, input logic w,
    input logic [3:0] ad, input logic [31:0] o);
    vec_t v;
    v.req = r; v.d = d; v.len = l; v.gnt = g; v.ack = a;
    v.busy = b; v.we = w; v.adr = ad; v.dout = o;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {18'd0, gnt, req_ack, busy, write_en, add_line, data_out};
  endfunction

  function automatic logic [63:0] expv(input vec_t v);
    return {18'd0, v.gnt, v.ack, v.busy, v.we, v.adr, v.dout};
  endfunction

  localparam logic [15:0] LA = 16'h5327;
  localparam logic [15:0] LZ = 16'h0000;
  localparam logic [15:0] L2 = 16'h0002;

  initial begin
    int k, wc, acks;
    // single burst, requester 1
    tv[0]  = mk(4'h0, 32'h0,  LA, 4'h0, 4'h0, 0, 0, 4'h0, 32'h0);
    tv[1]  = mk(4'h2, 32'hA0, LA, 4'h0, 4'h0, 0, 0, 4'h0, 32'h0);
    tv[2]  = mk(4'h2, 32'hA0, LA, 4'h2, 4'h2, 1, 0, 4'h0, 32'h0);
    tv[3]  = mk(4'h2, 32'hA1, LA, 4'h2, 4'h2, 1, 1, 4'h4, 32'hA0);
    tv[4]  = mk(4'h2, 32'hA2, LA, 4'h2, 4'h2, 1, 1, 4'h5, 32'hA1);
    tv[5]  = mk(4'h0, 32'h0,  LA, 4'h0, 4'h0, 0, 1, 4'h6, 32'hA2);
    tv[6]  = mk(4'h0, 32'h0,  LA, 4'h0, 4'h0, 0, 0, 4'h6, 32'hA2);
    // wrap, requester 2 base E len 3
    tv[7]  = mk(4'h4, 32'hB0, LA, 4'h0, 4'h0, 0, 0, 4'h6, 32'hA2);
    tv[8]  = mk(4'h4, 32'hB0, LA, 4'h4, 4'h4, 1, 0, 4'h6, 32'hA2);
    tv[9]  = mk(4'h4, 32'hB1, LA, 4'h4, 4'h4, 1, 1, 4'hE, 32'hB0);
    tv[10] = mk(4'h4, 32'hB2, LA, 4'h4, 4'h4, 1, 1, 4'hF, 32'hB1);
    tv[11] = mk(4'h4, 32'hB3, LA, 4'h4, 4'h4, 1, 1, 4'h0, 32'hB2);
    tv[12] = mk(4'h0, 32'h0,  LA, 4'h0, 4'h0, 0, 1, 4'h1, 32'hB3);
    // abort, requester 3 base 8 len 5, drops after 2 acks
    tv[13] = mk(4'h8, 32'hC0, LA, 4'h0, 4'h0, 0, 0, 4'h1, 32'hB3);
    tv[14] = mk(4'h8, 32'hC0, LA, 4'h8, 4'h8, 1, 0, 4'h1, 32'hB3);
    tv[15] = mk(4'h8, 32'hC1, LA, 4'h8, 4'h8, 1, 1, 4'h8, 32'hC0);
    tv[16] = mk(4'h0, 32'hC2, LA, 4'h8, 4'h0, 1, 1, 4'h9, 32'hC1);
    tv[17] = mk(4'h0, 32'h0,  LA, 4'h0, 4'h0, 0, 0, 4'h9, 32'hC1);
    // round robin, all requesting, len 0
    tv[18] = mk(4'hF, 32'hD0, LZ, 4'h0, 4'h0, 0, 0, 4'h9, 32'hC1);
    tv[19] = mk(4'hF, 32'hD0, LZ, 4'h1, 4'h1, 1, 0, 4'h9, 32'hC1);
    tv[20] = mk(4'hF, 32'hD1, LZ, 4'h0, 4'h0, 0, 1, 4'h3, 32'hD0);
    tv[21] = mk(4'hF, 32'hD1, LZ, 4'h2, 4'h2, 1, 0, 4'h3, 32'hD0);
    tv[22] = mk(4'hF, 32'hD2, LZ, 4'h0, 4'h0, 0, 1, 4'h4, 32'hD1);
    tv[23] = mk(4'hF, 32'hD2, LZ, 4'h4, 4'h4, 1, 0, 4'h4, 32'hD1);
    tv[24] = mk(4'hF, 32'hD3, LZ, 4'h0, 4'h0, 0, 1, 4'hE, 32'hD2);
    tv[25] = mk(4'hF, 32'hD3, LZ, 4'h8, 4'h8, 1, 0, 4'hE, 32'hD2);
    tv[26] = mk(4'hF, 32'hD4, LZ, 4'h0, 4'h0, 0, 1, 4'h8, 32'hD3);
    tv[27] = mk(4'hF, 32'hD4, LZ, 4'h1, 4'h1, 1, 0, 4'h8, 32'hD3);
    tv[28] = mk(4'h0, 32'h0,  LZ, 4'h0, 4'h0, 0, 1, 4'h3, 32'hD4);
    tv[29] = mk(4'h0, 32'h0,  LZ, 4'h0, 4'h0, 0, 0, 4'h3, 32'hD4);
    // non-owners toggle during requester 0 burst
    tv[30] = mk(4'h1, 32'hE0, L2, 4'h0, 4'h0, 0, 0, 4'h3, 32'hD4);
    tv[31] = mk(4'hD, 32'hE0, L2, 4'h1, 4'h1, 1, 0, 4'h3, 32'hD4);
    tv[32] = mk(4'h5, 32'hE1, L2, 4'h1, 4'h1, 1, 1, 4'h3, 32'hE0);
    tv[33] = mk(4'h9, 32'hE2, L2, 4'h1, 4'h1, 1, 1, 4'h4, 32'hE1);
    tv[34] = mk(4'hC, 32'hF0, L2, 4'h0, 4'h0, 0, 1, 4'h5, 32'hE2);
    tv[35] = mk(4'hC, 32'hF0, L2, 4'h4, 4'h4, 1, 0, 4'h5, 32'hE2);
    tv[36] = mk(4'h0, 32'h0,  L2, 4'h0, 4'h0, 0, 1, 4'hE, 32'hF0);
    tv[37] = mk(4'h0, 32'h0,  L2, 4'h0, 4'h0, 0, 0, 4'hE, 32'hF0);

    reset    = 1'b1;
    req      = '0;
    req_addr = 16'h8E43;
    req_len  = LA;
    req_data = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      reset    = 1'b0;
      req      = tv[i].req;
      req_len  = tv[i].len;
      req_data = {4{tv[i].d}};
      #1;
      chk($sformatf("vec%0d", i), outs(), expv(tv[i]));
    end

    // full 16-beat burst from address 0 on requester 0
    req_addr = 16'h8E40;
    req_len  = 16'h000F;
    k  = 0;
    wc = 0;
    for (int c = 0; c < 40 && wc < 16; c++) begin
      @(negedge clk);
      req      = (k < 16) ? 4'h1 : 4'h0;
      req_data = {4{32'(32'h100 + k)}};
      #1;
      if (req_ack[0]) k++;
      if (write_en) begin
        chk($sformatf("full_w%0d", wc),
            {28'd0, add_line, data_out},
            {28'd0, 4'(wc), 32'(32'h100 + wc)});
        wc++;
      end
    end
    chk("full_count", 64'(wc), 64'd16);

    // reset in the middle of a burst (req0 base 3 len 7, beat 2)
    @(negedge clk);
    req      = '0;
    req_addr = 16'h8E43;
    req_len  = 16'h0007;
    acks     = 0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      @(negedge clk);
      req      = 4'h1;
      req_data = {4{32'h55}};
      #1;
      if (req_ack[0]) acks++;
    end
    chk("rst_acks", 64'(acks), 64'd2);
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_state", outs(), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_quiet%0d", c),
          {62'd0, write_en, busy}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
